// File: rtl/axi_ctrl_write_arbiter_pkg.sv
// Types and helpers for the 2:1 AXI3 control-register write arbiter.
`include "axi_ctrl_defs.vh"

package axi_ctrl_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = `ST_IDLE,
    ADDR = `ST_ADDR,
    DATA = `ST_DATA,
    RESP = `ST_RESP
  } state_t;

  function automatic logic last_beat(
    input logic [7:0] cnt
  );
    return cnt == 8'd0;
  endfunction

endpackage

// File: rtl/axi_ctrl_defs.vh
// Encodings shared by the control-register write arbiter.
`ifndef AXI_CTRL_DEFS_VH
`define AXI_CTRL_DEFS_VH

`define ST_IDLE 2'd0
`define ST_ADDR 2'd1
`define ST_DATA 2'd2
`define ST_RESP 2'd3

`define RESP_OKAY 2'b00
`define RESP_SLVERR 2'b10

`define SIZE_4B 3'b010

`endif

// File: rtl/axi_ctrl_write_arbiter_rr_arb2.sv
// Two-way round-robin pick; the master not served last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    case (req)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_ctrl_write_arbiter.sv
// 2:1 AXI3 write arbiter, one transaction in flight, AW accept to B done.
module axi_ctrl_write_arbiter
  import axi_ctrl_write_arbiter_pkg::*;
#(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ID_W-1:0]   m0_awid,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [7:0]        m0_awlen,
  input  logic [2:0]        m0_awsize,
  input  logic [1:0]        m0_awburst,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [ID_W-1:0]   m0_wid,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic              m0_wlast,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  output logic [ID_W-1:0]   m0_bid,
  output logic [1:0]        m0_bresp,

  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ID_W-1:0]   m1_awid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [ID_W-1:0]   m1_wid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [ID_W-1:0]   m1_bid,
  output logic [1:0]        m1_bresp,

  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ID_W-1:0]   s_awid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [ID_W-1:0]   s_wid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [ID_W-1:0]   s_bid,
  input  logic [1:0]        s_bresp,

  output logic              grant,
  output logic              busy,
  output logic              protocol_err
);

  state_t     state;
  state_t     state_nxt;
  logic       grant_q;
  logic       grant_nxt;
  logic       last_q;
  logic       last_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       err_q;
  logic       err_nxt;
  logic       pick;
  logic       any_req;

  rr_arb2 u_rr (
    .req        ({m1_awvalid, m0_awvalid}),
    .last_grant (last_q),
    .grant      (pick),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt     <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  // Burst ends on the beat count; wlast only feeds the error flag.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (s_awvalid && s_awready) begin
          cnt_nxt   = s_awlen;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (s_wvalid && s_wready) begin
          if (s_wlast != last_beat(cnt))
            err_nxt = 1'b1;
          if (last_beat(cnt))
            state_nxt = RESP;
          else
            cnt_nxt = cnt - 8'd1;
        end
      end
      RESP: begin
        if (s_bvalid && s_bready) begin
          last_nxt  = grant_q;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_awid    = grant_q ? m1_awid    : m0_awid;
  assign s_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = grant_q ? m1_awlen   : m0_awlen;
  assign s_awsize  = grant_q ? m1_awsize  : m0_awsize;
  assign s_awburst = grant_q ? m1_awburst : m0_awburst;
  assign s_wid     = grant_q ? m1_wid     : m0_wid;
  assign s_wdata   = grant_q ? m1_wdata   : m0_wdata;
  assign s_wstrb   = grant_q ? m1_wstrb   : m0_wstrb;
  assign s_wlast   = grant_q ? m1_wlast   : m0_wlast;

  // Handshakes reach only the granted master and only in their own phase.
  always_comb begin
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    m0_bid     = '0;
    m1_bid     = '0;
    m0_bresp   = 2'b00;
    m1_bresp   = 2'b00;
    unique case (state)
      ADDR: begin
        s_awvalid = grant_q ? m1_awvalid : m0_awvalid;
        if (grant_q) m1_awready = s_awready;
        else         m0_awready = s_awready;
      end
      DATA: begin
        s_wvalid = grant_q ? m1_wvalid : m0_wvalid;
        if (grant_q) m1_wready = s_wready;
        else         m0_wready = s_wready;
      end
      RESP: begin
        s_bready = grant_q ? m1_bready : m0_bready;
        if (grant_q) begin
          m1_bvalid = s_bvalid;
          m1_bid    = s_bid;
          m1_bresp  = s_bresp;
        end else begin
          m0_bvalid = s_bvalid;
          m0_bid    = s_bid;
          m0_bresp  = s_bresp;
        end
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign busy         = (state != IDLE);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_axi_ctrl_write_arbiter.sv
// Randomized bench for the 2:1 AXI3 write arbiter with a transaction-level model.
`timescale 1ns/1ps

module tb_axi_ctrl_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast;
  logic m0_bvalid, m0_bready;
  logic [11:0] m0_awid, m0_wid, m0_bid;
  logic [31:0] m0_awaddr, m0_wdata;
  logic [7:0] m0_awlen;
  logic [2:0] m0_awsize;
  logic [1:0] m0_awburst, m0_bresp;
  logic [3:0] m0_wstrb;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
  logic m1_bvalid, m1_bready;
  logic [11:0] m1_awid, m1_wid, m1_bid;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [7:0] m1_awlen;
  logic [2:0] m1_awsize;
  logic [1:0] m1_awburst, m1_bresp;
  logic [3:0] m1_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic s_bvalid, s_bready;
  logic [11:0] s_awid, s_wid, s_bid;
  logic [31:0] s_awaddr, s_wdata;
  logic [7:0] s_awlen;
  logic [2:0] s_awsize;
  logic [1:0] s_awburst, s_bresp;
  logic [3:0] s_wstrb;
  logic grant, busy, protocol_err;

  axi_ctrl_write_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid),
    .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
    .m0_awburst(m0_awburst), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_wid(m0_wid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_wlast(m0_wlast), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_bid(m0_bid), .m0_bresp(m0_bresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid),
    .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_wid(m1_wid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_bid(m1_bid), .m1_bresp(m1_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .s_bresp(s_bresp),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  logic awr[2], wr[2], bv[2];
  logic [11:0] bid_o[2];
  logic [1:0] bresp_o[2];
  assign awr[0] = m0_awready;
  assign awr[1] = m1_awready;
  assign wr[0] = m0_wready;
  assign wr[1] = m1_wready;
  assign bv[0] = m0_bvalid;
  assign bv[1] = m1_bvalid;
  assign bid_o[0] = m0_bid;
  assign bid_o[1] = m1_bid;
  assign bresp_o[0] = m0_bresp;
  assign bresp_o[1] = m1_bresp;

  int ncmp = 0;
  int nerr = 0;

  logic [11:0] id[2];
  logic [31:0] addr[2];
  logic [7:0] len[2];
  logic [31:0] data[2][256];
  bit bad[2];
  bit en[2];
  bit aw_done[2];
  bit b_done[2];
  int wi[2];
  logic av_d[2], wv_d[2], br_d[2];
  bit last_g = 1'b1;
  bit err_m = 1'b0;
  bit e0, e1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_wlast(input int m, input int beat);
    if (bad[m]) return (len[m] == 8'd0) ? 1'b0 : (beat == 0);
    return beat == int'(len[m]);
  endfunction

  task automatic setup_m(input int m, input logic [11:0] i,
                         input logic [31:0] a, input logic [7:0] l,
                         input logic [31:0] d0, input bit b);
    id[m] = i;
    addr[m] = a;
    len[m] = l;
    bad[m] = b;
    data[m][0] = d0;
    for (int k = 1; k < 256; k++) data[m][k] = $urandom;
  endtask

  task automatic drive_m(input int m);
    logic av, wv, wl, br;
    logic [31:0] wd;
    int ix;
    ix = (wi[m] > 255) ? 255 : wi[m];
    av = en[m] && !aw_done[m];
    wv = en[m] && (wi[m] <= int'(len[m]));
    wd = data[m][ix];
    wl = exp_wlast(m, wi[m]);
    br = ($urandom % 3) != 0;
    av_d[m] = av;
    wv_d[m] = wv;
    br_d[m] = br;
    if (m == 0) begin
      m0_awvalid = av; m0_awid = id[0]; m0_awaddr = addr[0];
      m0_awlen = len[0]; m0_awsize = 3'b010; m0_awburst = 2'b01;
      m0_wvalid = wv; m0_wid = id[0]; m0_wdata = wd;
      m0_wstrb = 4'hf; m0_wlast = wl; m0_bready = br;
    end else begin
      m1_awvalid = av; m1_awid = id[1]; m1_awaddr = addr[1];
      m1_awlen = len[1]; m1_awsize = 3'b010; m1_awburst = 2'b01;
      m1_wvalid = wv; m1_wid = id[1]; m1_wdata = wd;
      m1_wstrb = 4'hf; m1_wlast = wl; m1_bready = br;
    end
  endtask

  task automatic clear_all();
    en[0] = 0;
    en[1] = 0;
    drive_m(0);
    drive_m(1);
    s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_bid = '0; s_bresp = 2'b00;
  endtask

  task automatic run_pair(input bit p0, input bit p1, input int dly,
                          input bit rand_resp, input int abort_beat);
    int cyc, nb, bcnt, oth;
    bit bpend, owner, to, bflag;
    logic [11:0] sid;
    logic [1:0] sresp;
    logic [7:0] slen;
    en[0] = p0; en[1] = p1;
    aw_done[0] = 0; aw_done[1] = 0;
    b_done[0] = 0; b_done[1] = 0;
    wi[0] = 0; wi[1] = 0;
    owner = (p0 && p1) ? ~last_g : p1;
    nb = 0; bpend = 0; bcnt = 0; cyc = 0; to = 0;
    sid = '0; sresp = 2'b00; slen = 8'd0;
    while (!((!p0 || b_done[0]) && (!p1 || b_done[1]))) begin
      if (cyc == 3000) begin to = 1; break; end
      cyc++;
      @(negedge clk);
      drive_m(0);
      drive_m(1);
      s_awready = 1'($urandom % 2);
      s_wready = ($urandom % 4) != 0;
      s_bvalid = bpend && (bcnt == 0);
      s_bid = sid;
      s_bresp = sresp;
      #1;
      oth = owner ? 0 : 1;
      chk("other_ready", {awr[oth], wr[oth], bv[oth]}, 3'b000);
      if (s_awvalid) begin
        chk("grant", grant, owner);
        chk("busy_aw", busy, 1'b1);
      end
      if (s_awvalid && s_awready) begin
        chk("aw_fwd", {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst},
            {id[owner], addr[owner], len[owner], 3'b010, 2'b01});
        slen = len[owner];
        sid = id[owner];
        nb = 0;
      end
      if (s_wvalid && s_wready) begin
        chk("w_fwd", {s_wid, s_wdata, s_wstrb, s_wlast},
            {id[owner], data[owner][nb & 255], 4'hf, exp_wlast(owner, nb)});
        nb++;
        if (nb == int'(slen) + 1) begin
          bpend = 1;
          bcnt = dly;
          sresp = rand_resp ? {1'($urandom % 2), 1'b0} : 2'b00;
        end
      end
      if (bpend) chk("busy_b", busy, 1'b1);
      bflag = 0;
      for (int m = 0; m < 2; m++) begin
        if (av_d[m] && awr[m]) aw_done[m] = 1;
        if (wv_d[m] && wr[m]) wi[m]++;
        if (bv[m] && br_d[m]) begin
          chk("b_owner", m, int'(owner));
          chk("b_fwd", {bid_o[m], bresp_o[m]}, {sid, sresp});
          chk("beats", nb, int'(slen) + 1);
          b_done[m] = 1;
          bflag = 1;
        end
      end
      if (s_bvalid && s_bready) bpend = 0;
      else if (bpend && bcnt > 0) bcnt--;
      if (bflag) begin
        last_g = owner;
        nb = 0;
        if (en[oth] && !b_done[oth]) owner = ~owner;
      end
      if (abort_beat >= 0 && nb == abort_beat) break;
    end
    chk("no_timeout", to, 1'b0);
    if (abort_beat < 0) begin
      if (p0 && bad[0]) err_m = 1;
      if (p1 && bad[1]) err_m = 1;
      chk("protocol_err", protocol_err, err_m);
      @(negedge clk);
      clear_all();
    end
  endtask

  initial begin
    setup_m(0, 12'h0, 32'h0, 8'd0, 32'h0, 0);
    setup_m(1, 12'h0, 32'h0, 8'd0, 32'h0, 0);
    clear_all();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_err", protocol_err, 1'b0);
    chk("rst_hs", {m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid,
                   m1_bvalid, s_awvalid, s_wvalid, s_bready}, 9'h0);
    rst = 0;

    setup_m(0, 12'h011, 32'h4000_0000, 8'd0, 32'h1000, 0);
    setup_m(1, 12'h022, 32'h4000_0004, 8'd0, 32'h2000, 0);
    run_pair(1, 1, 0, 0, -1);
    run_pair(1, 1, 1, 0, -1);
    run_pair(1, 0, 0, 0, -1);

    setup_m(1, 12'h123, 32'h4000_0008, 8'd3, 32'hcafe, 0);
    run_pair(0, 1, 2, 1, -1);

    setup_m(0, 12'h456, 32'h4000_000c, 8'd1, 32'hbeef, 1);
    run_pair(1, 0, 1, 1, -1);

    setup_m(0, 12'h0aa, 32'h4000_0010, 8'd2, 32'h1, 0);
    setup_m(1, 12'h0bb, 32'h4000_0014, 8'd1, 32'h2, 0);
    run_pair(1, 1, 20, 1, -1);

    setup_m(1, 12'h0cc, 32'h4000_0018, 8'd255, 32'h3, 0);
    run_pair(0, 1, 0, 1, -1);

    for (int k = 0; k < 25; k++) begin
      e0 = 1'($urandom % 2);
      e1 = e0 ? 1'($urandom % 2) : 1'b1;
      setup_m(0, 12'($urandom), $urandom, 8'($urandom % 8), $urandom,
              ($urandom % 4) == 0);
      setup_m(1, 12'($urandom), $urandom, 8'($urandom % 8), $urandom,
              ($urandom % 4) == 0);
      run_pair(e0, e1, int'($urandom % 6), 1, -1);
    end

    setup_m(0, 12'h0a5, 32'h4000_0020, 8'd3, 32'h55, 0);
    run_pair(1, 0, 0, 0, 2);
    @(negedge clk);
    chk("busy_pre_rst", busy, 1'b1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_grant", grant, 1'b0);
    chk("mid_rst_err", protocol_err, 1'b0);
    chk("mid_rst_hs", {m0_awready, m1_awready, m0_wready, m1_wready,
                       m0_bvalid, m1_bvalid, s_awvalid, s_wvalid,
                       s_bready}, 9'h0);
    @(negedge clk);
    clear_all();
    rst = 0;
    last_g = 1;
    err_m = 0;
    setup_m(1, 12'h5a5, 32'h4000_0024, 8'd0, 32'h77, 0);
    run_pair(0, 1, 3, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
